// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants, command codes and FSM state type for the SPI slave front end
package spi_pkg;

    localparam int FRAME_W     = 10;
    localparam int DATA_W      = 8;
    localparam int TX_WAIT_MAX = 4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4,
        ST_WAIT_TX   = 3'd5,
        ST_SHIFT_TX  = 3'd6,
        ST_DONE      = 3'd7
    } state_e;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// rtl/spi_slave_ctrl_if.sv - SPI pin and RAM-port bundle between the slave front end and its environment
interface spi_slave_ctrl_if;
    import spi_pkg::*;

    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

endinterface

// File: rtl/spi_tx_shifter.sv
// rtl/spi_tx_shifter.sv - loads the RAM read byte and drives it onto MISO MSB first
module spi_tx_shifter
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clr,
    input  logic [DATA_W-1:0] data,
    output logic              miso,
    output logic              done
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] byte_q, byte_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              active_q, active_d;

    // bit7 is presented the cycle after load; the last bit is held until cnt reaches DATA_W-1
    always_comb begin
        byte_d   = byte_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (clr) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (load) begin
            byte_d   = data;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                byte_d = {byte_q[DATA_W-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
            end
        end
    end

    // shifter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            byte_q   <= byte_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign miso = active_q & byte_q[DATA_W-1];
    assign done = active_q & (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI slave serial front end: MOSI frame deserialiser and MISO read-byte serialiser
module spi_slave_ctrl
    import spi_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    spi_slave_ctrl_if.slave bus
);
    localparam int CNT_W  = $clog2(FRAME_W + 1);
    localparam int WAIT_W = $clog2(TX_WAIT_MAX + 1);

    state_e              state_q, state_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [FRAME_W-1:0]  rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rd_addr_flag_q, rd_addr_flag_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                tx_load, tx_clr, tx_done, tx_miso;
    logic                frame_full, wait_expired;

    assign frame_full   = (bit_cnt_q == CNT_W'(FRAME_W));
    assign wait_expired = (wait_cnt_q == WAIT_W'(TX_WAIT_MAX - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // next state; SS_n high always returns to IDLE
    always_comb begin
        state_d = state_q;
        if (bus.SS_n) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_CHK_CMD;
                ST_CHK_CMD:   state_d = !bus.MOSI      ? ST_WRITE :
                                        rd_addr_flag_q ? ST_READ_DATA : ST_READ_ADD;
                ST_WRITE,
                ST_READ_ADD:  if (frame_full) state_d = ST_DONE;
                ST_READ_DATA: if (frame_full) state_d = ST_WAIT_TX;
                ST_WAIT_TX:   if (bus.tx_valid)    state_d = ST_SHIFT_TX;
                              else if (wait_expired) state_d = ST_DONE;
                ST_SHIFT_TX:  if (tx_done) state_d = ST_DONE;
                default:      state_d = state_q;
            endcase
        end
    end

    // datapath updates: frame shifting, rx commit, read-address flag, tx wait counter
    always_comb begin
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_flag_d = rd_addr_flag_q;
        bit_cnt_d      = bit_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        tx_load        = 1'b0;
        tx_clr         = 1'b0;
        if (bus.SS_n) begin
            bit_cnt_d  = '0;
            wait_cnt_d = '0;
            tx_clr     = 1'b1;
            // the read byte counts as consumed once the read-data frame was accepted
            if (state_q == ST_WAIT_TX || state_q == ST_SHIFT_TX) rd_addr_flag_d = 1'b0;
        end else begin
            case (state_q)
                ST_CHK_CMD: begin
                    shift_d   = {shift_q[FRAME_W-2:0], bus.MOSI};
                    bit_cnt_d = CNT_W'(1);
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    if (frame_full) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        if (state_q == ST_READ_ADD) rd_addr_flag_d = 1'b1;
                    end else begin
                        shift_d   = {shift_q[FRAME_W-2:0], bus.MOSI};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_TX: begin
                    if (bus.tx_valid) begin
                        tx_load        = 1'b1;
                        rd_addr_flag_d = 1'b0;
                        wait_cnt_d     = '0;
                    end else if (wait_expired) begin
                        rd_addr_flag_d = 1'b0;
                        wait_cnt_d     = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_flag_q <= 1'b0;
            bit_cnt_q      <= '0;
            wait_cnt_q     <= '0;
        end else begin
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_flag_q <= rd_addr_flag_d;
            bit_cnt_q      <= bit_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
        end
    end

    spi_tx_shifter u_tx_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tx_load),
        .clr   (tx_clr),
        .data  (bus.tx_data),
        .miso  (tx_miso),
        .done  (tx_done)
    );

    assign bus.MISO     = tx_miso;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule
